// File: rtl/local_bus_frame_ctrl.sv
// local_bus_frame_ctrl: parses UART command frames into register writes/reads/identify and returns CRC-8 framed responses.
module local_bus_frame_ctrl #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        lb_clk,
  input  logic        lb_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        lb_crc_error_n,
  output logic        ubus_identify
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CMD, DATA, CRC, EXEC, RESP} state_t;
  state_t        state;
  logic [7:0]    cmd;
  logic [7:0]    crc;
  logic [31:0]   dat;
  logic [1:0]    dcnt;
  logic [TW-1:0] tcnt;
  logic [47:0]   sh;
  logic [2:0]    rem;
  logic [7:0]    crc_nx;
  logic [7:0]    rsp_crc;
  logic          busy;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction
  // The CMD byte restarts the CRC so a stale value from an aborted frame never leaks in.
  assign crc_nx  = crc8(state == CMD ? 8'h00 : crc, rx_data);
  assign rsp_crc = cmd[7:6] == 2'b01
                 ? crc8(crc8(crc8(crc8(crc8(8'h00, cmd), rd_data[31:24]), rd_data[23:16]), rd_data[15:8]), rd_data[7:0])
                 : crc8(8'h00, cmd);
  assign busy = state == CMD || state == DATA || state == CRC;
  always_ff @(posedge lb_clk) begin
    if (lb_reset) begin
      state          <= IDLE;
      cmd            <= 8'h00;
      crc            <= 8'h00;
      dat            <= 32'h0;
      dcnt           <= 2'd0;
      tcnt           <= '0;
      sh             <= 48'h0;
      rem            <= 3'd0;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= 4'h0;
      wr_data        <= 32'h0;
      rd_addr        <= 4'h0;
      lb_crc_error_n <= 1'b1;
      ubus_identify  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: if (rx_valid && rx_data == 8'h55) state <= CMD;
        CMD: if (rx_valid) begin
          cmd     <= rx_data;
          crc     <= crc_nx;
          rd_addr <= rx_data[3:0];
          dcnt    <= 2'd0;
          state   <= rx_data[7:6] == 2'b00 ? DATA : CRC;
        end
        DATA: if (rx_valid) begin
          dat  <= {dat[23:0], rx_data};
          crc  <= crc_nx;
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd3) state <= CRC;
        end
        CRC: if (rx_valid) begin
          if (rx_data != crc) begin
            lb_crc_error_n <= 1'b0;
            state          <= IDLE;
          end else if (cmd[7:6] == 2'b11) begin
            state <= IDLE;
          end else begin
            state <= EXEC;
            if (cmd[7:6] == 2'b00) begin
              wr_en   <= 1'b1;
              wr_addr <= cmd[3:0];
              wr_data <= dat;
            end
          end
        end
        EXEC: begin
          lb_crc_error_n <= 1'b1;
          if (cmd[7:6] == 2'b10) ubus_identify <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= 8'hAA;
          sh       <= cmd[7:6] == 2'b01 ? {cmd, rd_data, rsp_crc} : {cmd, rsp_crc, 32'h0};
          rem      <= cmd[7:6] == 2'b01 ? 3'd6 : 3'd2;
          state    <= RESP;
        end
        RESP: if (tx_valid && tx_ready) begin
          if (rem == 3'd0) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_data <= sh[47:40];
            sh      <= {sh[39:0], 8'h00};
            rem     <= rem - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Inter-byte timeout only guards a partially received frame.
      if (busy && !rx_valid) begin
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_local_bus_frame_ctrl.sv
// tb_local_bus_frame_ctrl: table-driven frame vectors plus timing, timeout, backpressure and reset sequences.
module tb_local_bus_frame_ctrl;
  localparam int TO = 40;
  logic        clk = 1'b0;
  logic        lb_reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        lb_crc_error_n;
  logic        ubus_identify;
  logic [31:0] regs [16];
  logic [7:0]  txq [$];
  int          wr_cnt = 0;
  logic [3:0]  wa_last = 4'h0;
  logic [31:0] wd_last = 32'h0;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    int          n;
    logic [63:0] rx;
    int          ntx;
    logic [63:0] tx;
    int          nwr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        en;
    logic        id;
  } vec_t;
  vec_t v [8];
  local_bus_frame_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .lb_clk(clk), .lb_reset(lb_reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .lb_crc_error_n(lb_crc_error_n), .ubus_identify(ubus_identify)
  );
  always #5 clk = ~clk;
  assign rd_data = regs[rd_addr];
  always @(posedge clk) begin
    if (!lb_reset && tx_valid && tx_ready) txq.push_back(tx_data);
    if (wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wa_last <= wr_addr;
      wd_last <= wr_data;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // Bit-serial reference CRC-8 (poly 0x07) over the first n bytes, MSB-first.
  function automatic logic [7:0] crc_ref(input logic [63:0] b, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n * 8; k++) begin
      fb = c[7] ^ b[63 - k];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) send(b[63 - 8 * i -: 8]);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_tx(input string nm, input int q0, input logic [63:0] t, input int nt);
    chk({nm, " tx count"}, 64'(txq.size() - q0), 64'(nt));
    for (int i = 0; i < nt; i++)
      if (q0 + i < txq.size()) chk($sformatf("%s tx byte %0d", nm, i), 64'(txq[q0 + i]), 64'(t[63 - 8 * i -: 8]));
  endtask
  initial begin
    int          q0;
    int          w0;
    int          k;
    logic [7:0]  hold;
    logic [63:0] rdr;
    logic [63:0] wrf;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1] = 32'h12345678;
    regs[9] = 32'hCAFEF00D;
    rdr = {8'h41, 32'h12345678, 24'h0};
    wrf = {8'h03, 32'hDEADBEEF, 24'h0};
    v[0] = '{3, {8'h55, 8'h41, 8'hC0, 40'h0}, 7, {8'hAA, 8'h41, 32'h12345678, crc_ref(rdr, 5), 8'h0}, 0, 4'h0, 32'h0, 1'b1, 1'b0};
    v[1] = '{7, {8'h55, 8'h03, 32'hDEADBEEF, crc_ref(wrf, 5), 8'h0}, 3, {8'hAA, 8'h03, crc_ref({8'h03, 56'h0}, 1), 40'h0}, 1, 4'h3, 32'hDEADBEEF, 1'b1, 1'b0};
    v[2] = '{7, {8'h55, 8'h03, 32'hDEADBEEF, ~crc_ref(wrf, 5), 8'h0}, 0, 64'h0, 0, 4'h0, 32'h0, 1'b0, 1'b0};
    v[3] = v[0];
    v[4] = '{3, {8'h55, 8'h80, 8'h89, 40'h0}, 3, {8'hAA, 8'h80, 8'h89, 40'h0}, 0, 4'h0, 32'h0, 1'b1, 1'b1};
    v[5] = '{3, {8'h55, 8'hC5, crc_ref({8'hC5, 56'h0}, 1), 40'h0}, 0, 64'h0, 0, 4'h0, 32'h0, 1'b1, 1'b1};
    v[6] = '{8, {8'h12, 8'h55, 8'h0F, 32'h00000001, crc_ref({8'h0F, 32'h00000001, 24'h0}, 5)}, 3,
             {8'hAA, 8'h0F, crc_ref({8'h0F, 56'h0}, 1), 40'h0}, 1, 4'hF, 32'h00000001, 1'b1, 1'b1};
    v[7] = '{3, {8'h55, 8'h49, crc_ref({8'h49, 56'h0}, 1), 40'h0}, 7,
             {8'hAA, 8'h49, 32'hCAFEF00D, crc_ref({8'h49, 32'hCAFEF00D, 24'h0}, 5), 8'h0}, 0, 4'h0, 32'h0, 1'b1, 1'b1};
    lb_reset = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("reset tx_valid", 64'(tx_valid), 64'd0);
    chk("reset tx_data", 64'(tx_data), 64'd0);
    chk("reset wr_en", 64'(wr_en), 64'd0);
    chk("reset rd_addr", 64'(rd_addr), 64'd0);
    chk("reset crc_error_n", 64'(lb_crc_error_n), 64'd1);
    chk("reset identify", 64'(ubus_identify), 64'd0);
    lb_reset = 1'b0;
    tick();
    for (int n = 0; n < 8; n++) begin
      q0 = txq.size();
      w0 = wr_cnt;
      send_frame(v[n].rx, v[n].n);
      repeat (20) tick();
      chk_tx($sformatf("vec%0d", n), q0, v[n].tx, v[n].ntx);
      chk($sformatf("vec%0d wr count", n), 64'(wr_cnt - w0), 64'(v[n].nwr));
      if (v[n].nwr > 0) begin
        chk($sformatf("vec%0d wr_addr", n), 64'(wa_last), 64'(v[n].wa));
        chk($sformatf("vec%0d wr_data", n), 64'(wd_last), 64'(v[n].wd));
      end
      chk($sformatf("vec%0d crc_error_n", n), 64'(lb_crc_error_n), 64'(v[n].en));
      chk($sformatf("vec%0d identify", n), 64'(ubus_identify), 64'(v[n].id));
    end
    send_frame({8'h55, 8'h07, 32'h01020304, 16'h0}, 6);
    chk("timing wr_en before crc", 64'(wr_en), 64'd0);
    send(crc_ref({8'h07, 32'h01020304, 24'h0}, 5));
    chk("timing wr_en", 64'(wr_en), 64'd1);
    chk("timing wr_addr", 64'(wr_addr), 64'h7);
    chk("timing wr_data", 64'(wr_data), 64'h01020304);
    chk("timing tx_valid early", 64'(tx_valid), 64'd0);
    tick();
    chk("timing wr_en pulse", 64'(wr_en), 64'd0);
    chk("timing first tx_valid", 64'(tx_valid), 64'd1);
    chk("timing first tx_data", 64'(tx_data), 64'hAA);
    tick();
    chk("timing second tx_data", 64'(tx_data), 64'h07);
    repeat (5) tick();
    chk("timing wr_data held", 64'(wr_data), 64'h01020304);
    send_frame({8'h55, 8'h41, 8'h3F, 40'h0}, 3);
    chk("crc err fall", 64'(lb_crc_error_n), 64'd0);
    send_frame({8'h55, 8'h41, 8'hC0, 40'h0}, 3);
    repeat (3) tick();
    chk("crc err restore", 64'(lb_crc_error_n), 64'd1);
    repeat (10) tick();
    q0 = txq.size();
    w0 = wr_cnt;
    send_frame({8'h00, 8'h55, 8'h03, 8'hDE, 32'h0}, 4);
    repeat (TO + 5) tick();
    send_frame({8'h55, 8'h41, 8'hC0, 40'h0}, 3);
    repeat (20) tick();
    chk("timeout wr count", 64'(wr_cnt - w0), 64'd0);
    chk_tx("timeout", q0, v[0].tx, 7);
    q0 = txq.size();
    send(8'h55);
    repeat (TO - 2) tick();
    send_frame({8'h41, 8'hC0, 48'h0}, 2);
    repeat (20) tick();
    chk_tx("slow bytes", q0, v[0].tx, 7);
    q0 = txq.size();
    send_frame({8'h55, 8'h41, 8'hC0, 40'h0}, 3);
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    chk("bp tx_valid seen", 64'(tx_valid), 64'd1);
    tick();
    tick();
    tx_ready = 1'b0;
    tick();
    hold = tx_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp stable %0d", i), {55'h0, tx_valid, tx_data}, {55'h0, 1'b1, hold});
    end
    tx_ready = 1'b1;
    repeat (15) tick();
    chk_tx("bp", q0, v[0].tx, 7);
    w0 = wr_cnt;
    send_frame({8'h55, 8'h03, 8'hDE, 40'h0}, 3);
    lb_reset = 1'b1;
    tick();
    chk("rst tx_valid", 64'(tx_valid), 64'd0);
    chk("rst tx_data", 64'(tx_data), 64'd0);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);
    chk("rst wr_data", 64'(wr_data), 64'd0);
    chk("rst rd_addr", 64'(rd_addr), 64'd0);
    chk("rst crc_error_n", 64'(lb_crc_error_n), 64'd1);
    chk("rst identify", 64'(ubus_identify), 64'd0);
    lb_reset = 1'b0;
    tick();
    send_frame({8'hAD, 8'hBE, 8'hEF, crc_ref(wrf, 5), 32'h0}, 4);
    repeat (10) tick();
    chk("rst no write", 64'(wr_cnt - w0), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/local_bus_frame_ctrl.md
# local_bus_frame_ctrl

Command-frame controller for the local-bus register block. It parses a byte stream from the UART receiver into write, read and identify commands, and drives single-cycle writes into the reg2nd bank. It samples the nd2reg status words for reads, returns acknowledge/response frames to the UART transmitter, and generates `lb_crc_error_n` and `ubus_identify`. It sits between the UART byte layer and the register bank, all in the `lb_clk` domain.

## Interface
- `TIMEOUT_CYC`, default 100000: inter-byte timeout in `lb_clk` cycles; a partial frame is aborted when it expires.
- `lb_clk` in 1: sole clock; all logic rising-edge.
- `lb_reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: byte offered; held until accepted.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `wr_en` out 1: one-cycle write strobe to the reg2nd bank.
- `wr_addr` out 4: register index 0–15.
- `wr_data` out 32: write data.
- `rd_addr` out 4: read index; the external mux returns `rd_data` in the same cycle.
- `rd_data` in 32: status word (nd2reg_0..7 for indices 0–7, reg2nd readback for indices 8–15).
- `lb_crc_error_n` out 1: low after a CRC-failed frame.
- `ubus_identify` out 1: sticky identify flag.

## Operation
- Request frame: `0x55`, CMD, then 4 data bytes MSB-first (write only), then CRC.
- CRC is CRC-8: poly 0x07, init 0x00, no reflection, no final XOR. It covers CMD and the data bytes only.
- CMD field decode:
  - `CMD[7:6]=00`: write; `CMD[3:0]` is the address.
  - `01`: read.
  - `10`: identify.
  - `11`: reserved.
- States: IDLE, CMD, DATA, CRC, EXEC, RESP.
- IDLE: bytes other than `0x55` are discarded; `0x55` moves to CMD.
- CMD: latch CMD and start the CRC. Write goes to DATA (4-byte counter); read, identify and reserved go to CRC.
- CRC: compare the received byte with the running CRC.
  - Match, reserved CMD: return to IDLE, no response, flags unchanged.
  - Match, other CMD: go to EXEC.
  - Mismatch: `lb_crc_error_n`=0 and return to IDLE; no write, no response.
- EXEC (one cycle):
  - Write: `wr_en`=1 with the latched address and data.
  - Read: capture `rd_data` into the response buffer.
  - Identify: set `ubus_identify`=1.
  - Then go to RESP.
- The first good frame after an error sets `lb_crc_error_n` back to 1 in EXEC.
- RESP sends `0xAA`, CMD echo, [4 data bytes MSB-first for read], then the CRC over echo + data. Return to IDLE after the last byte is accepted.
- `rx_valid` bytes arriving during EXEC or RESP are dropped.
- Timeout:
  - The counter clears on every accepted `rx_valid`.
  - In CMD, DATA or CRC, reaching `TIMEOUT_CYC` returns the block to IDLE with no side effects.
  - The counter is not active in IDLE or RESP.
- `ubus_identify` clears only on reset.
- `rd_addr` holds the latched CMD address from the CMD state onward.

## Timing
- Reset values:
  - `tx_valid`=0, `tx_data`=0
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0
  - `lb_crc_error_n`=1, `ubus_identify`=0
  - state IDLE, CRC register 0x00
- Reset during any state aborts the frame in the next cycle. No `wr_en` is issued and `tx_valid` drops.
- `wr_en` asserts exactly 1 cycle after the cycle in which the matching CRC byte is strobed. `wr_addr` and `wr_data` stay stable until the next write.
- The first response byte (`tx_valid`=1, `tx_data`=0xAA) appears 2 cycles after the CRC byte strobe.
- Each response byte advances on the cycle after `tx_valid && tx_ready`. With `tx_ready` held at 1, bytes go out back-to-back, one per cycle.
- `lb_crc_error_n` falls 1 cycle after the bad CRC byte strobe.
- The CRC update is combinational per byte and registered on the `rx_valid` cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted while in IDLE, CMD, DATA or CRC.

## Test plan
- Read: rx `55 41 C0` with index 1's `rd_data`=0x12345678 → no `wr_en`; tx `AA 41 12 34 56 78 <crc>`. The CRC must match the bench CRC-8 model.
- Write: rx `55 03 DE AD BE EF <crc>` → `wr_en` one cycle with `wr_addr`=3, `wr_data`=0xDEADBEEF, 1 cycle after the CRC strobe. Then tx `AA 03 <crc(03)>`.
- CRC error: write frame with its last byte inverted → `lb_crc_error_n`=0, no `wr_en`, no tx. A following good read `55 41 C0` restores `lb_crc_error_n`=1.
- Identify: rx `55 80 89` → `ubus_identify`=1 in EXEC, tx `AA 80 89`. The flag stays 1 through later frames until `lb_reset`.
- Timeout and noise: rx `00 55 03 DE`, then idle `TIMEOUT_CYC` cycles, then `55 41 C0` → no write; only the read response appears.
- Backpressure and reset: hold `tx_ready`=0 for 10 cycles mid-response → `tx_data` stable, nothing lost. Assert `lb_reset` mid-DATA → all outputs return to their reset values the next cycle.
